// File: rtl/regfile_mp_pkg.sv
// Shared types and default widths for the multi-port register file.
package regfile_mp_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: sweeps every address once after reset or on request,
// issuing one zero-write per cycle while busy.
module regfile_clr_seq
    import regfile_mp_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    clr_state_e        state;
    logic [ADDR_W-1:0] clr_ptr;

    // Requests arriving mid-sweep are ignored; only reset restarts the sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_ptr <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_ptr == LAST_ADDR) begin
                        state   <= IDLE;
                        clr_ptr <= '0;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_ptr <= '0;
                end
            endcase
        end
    end

    assign busy     = (state == CLEAR);
    assign clr_we   = busy;
    assign clr_addr = clr_ptr;

endmodule

// File: rtl/regfile_mp.sv
// Register file with one synchronous write port, two combinational read ports,
// optional write bypass, optional zero register and a hardware clear sweep.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              clr_req,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_ok;

    regfile_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign wr_ok = we & ~busy & ~(ZERO_REG & (waddr == '0));

    // No reset on storage: the sweep is what makes contents defined.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] raddr);
        logic [DATA_W-1:0] val;
        if (busy) begin
            val = '0;
        end else if (ZERO_REG && (raddr == '0)) begin
            val = '0;
        end else if (BYPASS && wr_ok && (raddr == waddr)) begin
            val = wdata;
        end else begin
            val = mem[raddr];
        end
        return val;
    endfunction

    always_comb begin
        rdata_a = read_port(raddr_a);
        rdata_b = read_port(raddr_b);
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp; three parameter variants share
// the same stimulus and are each compared against a behavioural model.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, we, clr_req;
    logic [3:0] waddr, raddr_a, raddr_b;
    logic [7:0] wdata;

    logic [7:0] rdA0, rdB0, rdA1, rdB1, rdA2, rdB2;
    logic       busy0, busy1, busy2;

    int   checks = 0;
    int   errors = 0;
    bit   armed = 1'b0;
    logic sampledBusy;

    logic [7:0] mdl [3][16];
    int         busyLeft [3];

    regfile_mp #(.ZERO_REG(1'b0), .BYPASS(1'b1)) u_def (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rdA0), .raddr_b(raddr_b), .rdata_b(rdB0),
        .clr_req(clr_req), .busy(busy0)
    );

    regfile_mp #(.ZERO_REG(1'b0), .BYPASS(1'b0)) u_nobyp (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rdA1), .raddr_b(raddr_b), .rdata_b(rdB1),
        .clr_req(clr_req), .busy(busy1)
    );

    regfile_mp #(.ZERO_REG(1'b1), .BYPASS(1'b1)) u_zero (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rdA2), .raddr_b(raddr_b), .rdata_b(rdB2),
        .clr_req(clr_req), .busy(busy2)
    );

    function automatic bit zr(int k);
        return k == 2;
    endfunction

    function automatic bit byp(int k);
        return k != 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit wrOk(int k);
        return we && (busyLeft[k] == 0) && !(zr(k) && (waddr == 4'd0));
    endfunction

    function automatic logic [7:0] expRead(int k, logic [3:0] ra);
        if (busyLeft[k] > 0) return 8'h00;
        if (zr(k) && ra == 4'd0) return 8'h00;
        if (byp(k) && wrOk(k) && ra == waddr) return wdata;
        return mdl[k][ra];
    endfunction

    function automatic logic [7:0] getA(int k);
        case (k)
            0:       return rdA0;
            1:       return rdA1;
            default: return rdA2;
        endcase
    endfunction

    function automatic logic [7:0] getB(int k);
        case (k)
            0:       return rdB0;
            1:       return rdB1;
            default: return rdB2;
        endcase
    endfunction

    function automatic logic getBusy(int k);
        case (k)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    task automatic checkAll();
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("busy[%0d]", k), {31'd0, getBusy(k)}, {31'd0, busyLeft[k] > 0});
            checkOutput($sformatf("rdata_a[%0d] @%0d", k, raddr_a), {24'd0, getA(k)}, {24'd0, expRead(k, raddr_a)});
            checkOutput($sformatf("rdata_b[%0d] @%0d", k, raddr_b), {24'd0, getB(k)}, {24'd0, expRead(k, raddr_b)});
        end
    endtask

    // Clear behaviour is modelled as "contents become zero, busy for DEPTH edges".
    task automatic modelEdge();
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                busyLeft[k] = 16;
                for (int i = 0; i < 16; i++) mdl[k][i] = 8'h00;
            end else if (busyLeft[k] > 0) begin
                busyLeft[k]--;
            end else begin
                if (wrOk(k)) mdl[k][waddr] = wdata;
                if (clr_req) begin
                    busyLeft[k] = 16;
                    for (int i = 0; i < 16; i++) mdl[k][i] = 8'h00;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic w, input logic [3:0] wa,
                                 input logic [7:0] wd, input logic [3:0] ra,
                                 input logic [3:0] rb, input logic cr);
        rst = r; we = w; waddr = wa; wdata = wd;
        raddr_a = ra; raddr_b = rb; clr_req = cr;
        @(negedge clk);
        sampledBusy = busy0;
        if (armed) checkAll();
        @(posedge clk);
        modelEdge();
        if (r) armed = 1'b1;
        #1;
    endtask

    task automatic idle(input logic [3:0] ra, input logic [3:0] rb);
        applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, ra, rb, 1'b0);
    endtask

    task automatic readAll();
        for (int i = 0; i < 16; i++) idle(4'(i), 4'(15 - i));
    endtask

    // Counts busy cycles while hammering addr 2 with writes; bounded at 64.
    task automatic runBusy(input int clrAt, input int rstAt, output int n);
        int i;
        n = 0;
        i = 0;
        do begin
            applyStimulus(i == rstAt, busyLeft[0] > 0, 4'd2, 8'h99, 4'd2, 4'(i), i == clrAt);
            if (sampledBusy === 1'b1) n++;
            i++;
        end while (sampledBusy === 1'b1 && i < 64);
    endtask

    initial begin
        int n;
        logic [3:0] wa;
        for (int k = 0; k < 3; k++) begin
            busyLeft[k] = 0;
            for (int i = 0; i < 16; i++) mdl[k][i] = 8'h00;
        end
        rst = 1'b0; we = 1'b0; clr_req = 1'b0;
        waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
        #1;

        $display("[TB] reset then idle");
        applyStimulus(1'b1, 1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b0);
        runBusy(-1, -1, n);
        checkOutput("busyAfterRst", n, 16);
        readAll();

        $display("[TB] basic write/read");
        applyStimulus(1'b0, 1'b1, 4'd3, 8'hA5, 4'd3, 4'd7, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'd7, 8'h3C, 4'd3, 4'd7, 1'b0);
        idle(4'd3, 4'd7);
        idle(4'd3, 4'd3);

        $display("[TB] bypass");
        applyStimulus(1'b0, 1'b1, 4'd5, 8'h77, 4'd5, 4'd5, 1'b0);
        idle(4'd5, 4'd5);

        $display("[TB] zero register");
        applyStimulus(1'b0, 1'b1, 4'd0, 8'hFF, 4'd0, 4'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'd1, 8'h11, 4'd0, 4'd1, 1'b0);
        idle(4'd0, 4'd1);

        $display("[TB] clear request with writes during busy");
        for (int i = 0; i < 16; i++)
            applyStimulus(1'b0, 1'b1, 4'(i), 8'(i + 1), 4'(i), 4'(15 - i), 1'b0);
        readAll();
        applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 4'd2, 4'd2, 1'b1);
        runBusy(5, -1, n);
        checkOutput("busyAfterClr", n, 16);
        readAll();

        $display("[TB] reset mid-sweep");
        for (int i = 0; i < 16; i++)
            applyStimulus(1'b0, 1'b1, 4'(i), 8'(8'hF0 ^ i), 4'(i), 4'(i), 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b1);
        runBusy(-1, 5, n);
        checkOutput("busyAfterMidRst", n, 22);
        readAll();

        $display("[TB] random traffic");
        for (int c = 0; c < 500; c++) begin
            wa = 4'($urandom_range(0, 15));
            applyStimulus($urandom_range(0, 99) == 0,
                          1'($urandom_range(0, 1)),
                          wa,
                          8'($urandom_range(0, 255)),
                          ($urandom_range(0, 1) == 1) ? wa : 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)),
                          $urandom_range(0, 39) == 0);
        end
        for (int c = 0; c < 20; c++) idle(4'(c), 4'(c + 3));
        readAll();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
